// File: rtl/wb_stage.sv
// Writeback stage: extends load data, arbitrates LSU/ALU results through a one-entry
// holding buffer and registers the register-file write. Optional bypass port: WB_FWD_EN.
module wb_stage #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [AW-1:0]   alu_rd_addr,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [AW-1:0]   lsu_rd_addr,
  input  logic [XLEN-1:0] lsu_data,
  input  logic [2:0]      lsu_funct3,
  input  logic [1:0]      lsu_byte_off,
  output logic [XLEN-1:0] rd,
  output logic [AW-1:0]   rd_addr,
  output logic            w_en,
  output logic            load_err,
  output logic            fwd_valid,
  output logic [AW-1:0]   fwd_addr,
  output logic [XLEN-1:0] fwd_data
);

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  logic            hold_valid_reg, hold_valid_next;
  logic [AW-1:0]   hold_addr_reg, hold_addr_next;
  logic [XLEN-1:0] hold_data_reg, hold_data_next;
  logic            w_en_reg, w_en_next;
  logic [AW-1:0]   rd_addr_reg, rd_addr_next;
  logic [XLEN-1:0] rd_reg, rd_next;
  logic            load_err_reg, load_err_next;

  logic [7:0]      byte_lane [4];
  logic [15:0]     half_lane [2];
  logic [7:0]      sel_byte;
  logic [15:0]     sel_half;
  logic [XLEN-1:0] load_ext;
  logic            load_bad;

  logic            sel_valid;
  logic            sel_bad;
  logic [AW-1:0]   sel_addr;
  logic [XLEN-1:0] sel_data;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte
      assign byte_lane[gi] = lsu_data[8*gi +: 8];
    end
    for (gi = 0; gi < 2; gi++) begin : g_half
      assign half_lane[gi] = lsu_data[16*gi +: 16];
    end
  endgenerate

  assign sel_byte = byte_lane[lsu_byte_off];
  assign sel_half = half_lane[lsu_byte_off[1]];

  always_comb begin
    load_ext = '0;
    load_bad = 1'b0;
    case (lsu_funct3)
      F3_LB:   load_ext = {{(XLEN-8){sel_byte[7]}}, sel_byte};
      F3_LBU:  load_ext = {{(XLEN-8){1'b0}}, sel_byte};
      F3_LH:   load_ext = {{(XLEN-16){sel_half[15]}}, sel_half};
      F3_LHU:  load_ext = {{(XLEN-16){1'b0}}, sel_half};
      F3_LW:   load_ext = lsu_data;
      default: load_bad = 1'b1;
    endcase
  end

  // Any buffered entry blocks both sources until it has drained.
  assign alu_ready = !hold_valid_reg;
  assign lsu_ready = !hold_valid_reg;

  always_comb begin
    hold_valid_next = hold_valid_reg;
    hold_addr_next  = hold_addr_reg;
    hold_data_next  = hold_data_reg;
    sel_valid       = 1'b0;
    sel_bad         = 1'b0;
    sel_addr        = '0;
    sel_data        = '0;

    if (hold_valid_reg) begin
      sel_valid       = 1'b1;
      sel_addr        = hold_addr_reg;
      sel_data        = hold_data_reg;
      hold_valid_next = 1'b0;
    end else if (lsu_valid) begin
      sel_valid = 1'b1;
      sel_bad   = load_bad;
      sel_addr  = lsu_rd_addr;
      sel_data  = load_ext;
      if (alu_valid) begin
        hold_valid_next = 1'b1;
        hold_addr_next  = alu_rd_addr;
        hold_data_next  = alu_data;
      end
    end else if (alu_valid) begin
      sel_valid = 1'b1;
      sel_addr  = alu_rd_addr;
      sel_data  = alu_data;
    end

    // Flush still lets the handshakes complete but throws the results away.
    if (flush) begin
      hold_valid_next = 1'b0;
      sel_valid       = 1'b0;
    end
  end

  always_comb begin
    w_en_next     = 1'b0;
    rd_addr_next  = '0;
    rd_next       = '0;
    load_err_next = 1'b0;
    if (sel_valid) begin
      if (sel_bad) begin
        load_err_next = 1'b1;
      end else if (sel_addr != '0) begin
        w_en_next    = 1'b1;
        rd_addr_next = sel_addr;
        rd_next      = sel_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid_reg <= 1'b0;
      hold_addr_reg  <= '0;
      hold_data_reg  <= '0;
      w_en_reg       <= 1'b0;
      rd_addr_reg    <= '0;
      rd_reg         <= '0;
      load_err_reg   <= 1'b0;
    end else begin
      hold_valid_reg <= hold_valid_next;
      hold_addr_reg  <= hold_addr_next;
      hold_data_reg  <= hold_data_next;
      w_en_reg       <= w_en_next;
      rd_addr_reg    <= rd_addr_next;
      rd_reg         <= rd_next;
      load_err_reg   <= load_err_next;
    end
  end

  assign w_en     = w_en_reg;
  assign rd_addr  = rd_addr_reg;
  assign rd       = rd_reg;
  assign load_err = load_err_reg;

`ifdef WB_FWD_EN
  assign fwd_valid = w_en_reg && (rd_addr_reg != '0);
  assign fwd_addr  = rd_addr_reg;
  assign fwd_data  = rd_reg;
`else
  assign fwd_valid = 1'b0;
  assign fwd_addr  = '0;
  assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Randomized self-checking bench for wb_stage against a queue-based behavioural model.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd_addr;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd_addr;
  logic [31:0] lsu_data;
  logic [2:0]  lsu_funct3;
  logic [1:0]  lsu_byte_off;
  logic [31:0] rd;
  logic [4:0]  rd_addr;
  logic        w_en;
  logic        load_err;
  logic        fwd_valid;
  logic [4:0]  fwd_addr;
  logic [31:0] fwd_data;

  wb_stage #(.XLEN(32), .AW(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd_addr(alu_rd_addr), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd_addr(lsu_rd_addr), .lsu_data(lsu_data),
    .lsu_funct3(lsu_funct3), .lsu_byte_off(lsu_byte_off),
    .rd(rd), .rd_addr(rd_addr), .w_en(w_en), .load_err(load_err),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } entry_t;

  entry_t hold_q[$];
  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;
  bit          exp_w_en, exp_err, exp_ready;
  logic [4:0]  exp_addr;
  logic [31:0] exp_rd;

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  // Load extension from the ISA definition: shift the word down, mask, sign-fill.
  function automatic logic [31:0] m_ext(logic [31:0] d, logic [2:0] f, logic [1:0] off, output bit bad);
    logic [31:0] v;
    bad = 0;
    v = 0;
    case (f)
      3'd0, 3'd4: begin
        v = (d >> (8 * off)) & 32'hff;
        if (f == 3'd0 && v >= 32'h80) v = v | 32'hffff_ff00;
      end
      3'd1, 3'd5: begin
        v = (d >> (16 * (off / 2))) & 32'hffff;
        if (f == 3'd1 && v >= 32'h8000) v = v | 32'hffff_0000;
      end
      3'd2: v = d;
      default: bad = 1;
    endcase
    return v;
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("w_en", w_en, exp_w_en);
      chk("load_err", load_err, exp_err);
      chk("alu_ready", alu_ready, exp_ready);
      chk("lsu_ready", lsu_ready, exp_ready);
      if (exp_w_en) begin
        chk("rd_addr", rd_addr, exp_addr);
        chk("rd", rd, exp_rd);
      end
`ifdef WB_FWD_EN
      chk("fwd_valid", fwd_valid, exp_w_en);
      if (exp_w_en) begin
        chk("fwd_addr", fwd_addr, exp_addr);
        chk("fwd_data", fwd_data, exp_rd);
      end
`else
      chk("fwd_valid_tied", fwd_valid, 0);
      chk("fwd_addr_tied", fwd_addr, 0);
      chk("fwd_data_tied", fwd_data, 0);
`endif
    end
  end

  // Predict the next registered write from the present inputs, then advance one clock.
  task automatic step();
    bit nw, ne, bad;
    logic [4:0]  na;
    logic [31:0] nd, ext;
    entry_t e;
    nw = 0; ne = 0; na = 0; nd = 0;
    if (!rst_n) begin
      hold_q.delete();
    end else if (flush) begin
      hold_q.delete();
    end else if (hold_q.size() > 0) begin
      e = hold_q.pop_front();
      nw = (e.addr != 0); na = e.addr; nd = e.data;
    end else begin
      if (lsu_valid) begin
        ext = m_ext(lsu_data, lsu_funct3, lsu_byte_off, bad);
        if (bad) ne = 1;
        else if (lsu_rd_addr != 0) begin nw = 1; na = lsu_rd_addr; nd = ext; end
        if (alu_valid) hold_q.push_back('{alu_rd_addr, alu_data});
      end else if (alu_valid && alu_rd_addr != 0) begin
        nw = 1; na = alu_rd_addr; nd = alu_data;
      end
    end
    @(posedge clk);
    #1;
    exp_w_en = nw; exp_addr = na; exp_rd = nd; exp_err = ne;
    exp_ready = (hold_q.size() == 0);
  endtask

  task automatic set_idle();
    flush = 0; alu_valid = 0; lsu_valid = 0;
    alu_rd_addr = 0; alu_data = 0; lsu_rd_addr = 0; lsu_data = 0;
    lsu_funct3 = 3'd2; lsu_byte_off = 0;
  endtask

  task automatic set_alu(logic [4:0] a, logic [31:0] d);
    alu_valid = 1; alu_rd_addr = a; alu_data = d;
  endtask

  task automatic set_lsu(logic [4:0] a, logic [31:0] d, logic [2:0] f, logic [1:0] off);
    lsu_valid = 1; lsu_rd_addr = a; lsu_data = d; lsu_funct3 = f; lsu_byte_off = off;
  endtask

  task automatic do_reset(int cycles);
    rst_n = 0;
    hold_q.delete();
    exp_w_en = 0; exp_err = 0; exp_addr = 0; exp_rd = 0; exp_ready = 1;
    #1;
    chk("reset_w_en_immediate", w_en, 0);
    chk("reset_ready", alu_ready, 1);
    for (int i = 0; i < cycles; i++) step();
    rst_n = 1;
  endtask

  initial begin
    bit bad;
    logic [31:0] v;
    set_idle();
    rst_n = 0;
    #1;
    chk("reset_rd", rd, 0);
    chk("reset_rd_addr", rd_addr, 0);
    chk("reset_load_err", load_err, 0);
    chk("reset_lsu_ready", lsu_ready, 1);
    exp_w_en = 0; exp_err = 0; exp_addr = 0; exp_rd = 0; exp_ready = 1;
    cmp_en = 1;
    step(); step();
    rst_n = 1;
    step();

    // Pin the extension model against hand-computed values.
    v = m_ext(32'h80ff_7f81, 3'd0, 2'd0, bad); chk("model_lb", v, 32'hffff_ff81);
    v = m_ext(32'h80ff_7f81, 3'd4, 2'd3, bad); chk("model_lbu", v, 32'h0000_0080);
    v = m_ext(32'h80ff_7f81, 3'd1, 2'd2, bad); chk("model_lh", v, 32'hffff_80ff);
    v = m_ext(32'h80ff_7f81, 3'd5, 2'd1, bad); chk("model_lhu", v, 32'h0000_7f81);

    // Single ALU write
    set_alu(5, 32'hfefe);
    chk("alu_ready_pre", alu_ready, 1);
    step(); set_idle();
    chk("alu_w_en", w_en, 1); chk("alu_addr", rd_addr, 5); chk("alu_rd", rd, 32'hfefe);
    chk("alu_ready_post", alu_ready, 1);

    // Contention: lsu first, alu drains next cycle
    set_lsu(3, 32'hbadd, 3'd2, 0); set_alu(4, 32'habba);
    step(); set_idle();
    chk("cont1_w_en", w_en, 1); chk("cont1_addr", rd_addr, 3); chk("cont1_rd", rd, 32'hbadd);
    chk("cont1_alu_ready", alu_ready, 0); chk("cont1_lsu_ready", lsu_ready, 0);
    step();
    chk("cont2_w_en", w_en, 1); chk("cont2_addr", rd_addr, 4); chk("cont2_rd", rd, 32'habba);
    step();
    chk("cont3_ready", alu_ready, 1);

    // Load extension
    set_lsu(7, 32'h80ff_7f81, 3'd0, 0); step(); chk("lb_rd", rd, 32'hffff_ff81);
    set_lsu(7, 32'h80ff_7f81, 3'd4, 3); step(); chk("lbu_rd", rd, 32'h0000_0080);
    set_lsu(7, 32'h80ff_7f81, 3'd1, 2); step(); chk("lh_rd", rd, 32'hffff_80ff);
    set_lsu(7, 32'h80ff_7f81, 3'd5, 1); step(); chk("lhu_rd", rd, 32'h0000_7f81);
    set_idle(); step();

    // x0 write suppressed
    set_alu(0, 32'h6969);
    chk("x0_ready", alu_ready, 1);
    step(); set_idle();
    chk("x0_w_en", w_en, 0); chk("x0_fwd_valid", fwd_valid, 0);

    // Reserved funct3
    set_lsu(9, 32'h1234_5678, 3'b011, 0);
    step(); set_idle();
    chk("bad_w_en", w_en, 0); chk("bad_load_err", load_err, 1);
    step();
    chk("bad_load_err_clear", load_err, 0);

    // Flush discards the held entry
    set_lsu(3, 32'h1111, 3'd2, 0); set_alu(4, 32'h2222);
    step(); set_idle();
    chk("flush_held", alu_ready, 0);
    flush = 1;
    step(); flush = 0;
    chk("flush_no_write", w_en, 0); chk("flush_ready", alu_ready, 1);
    step();
    chk("flush_after", w_en, 0);

    // Reset while holding
    set_lsu(3, 32'h3333, 3'd2, 0); set_alu(4, 32'h4444);
    step(); set_idle();
    do_reset(2);
    step();
    chk("rst_release_no_write", w_en, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      flush       = ($urandom_range(0, 11) == 0);
      alu_valid   = $urandom_range(0, 1);
      lsu_valid   = $urandom_range(0, 1);
      alu_rd_addr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      lsu_rd_addr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      alu_data    = $urandom;
      lsu_data    = $urandom;
      lsu_funct3  = 3'($urandom_range(0, 7));
      lsu_byte_off = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 299) == 0) do_reset(1);
      else step();
    end

    set_idle();
    step();
    cmp_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
